// File: rtl/lognot_cosim_sequencer.sv
// lognot_cosim_sequencer: drives directed+LFSR vectors into the packed logical-NOT datapath and checks results against a golden model
module lognot_cosim_sequencer #(
  parameter int LATENCY = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      num_vectors,
  input  logic [127:0]     seed,
  output logic [127:0]     dut_in,
  input  logic [127:0]     dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             first_fail_valid,
  output logic [31:0]      first_fail_idx
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int D = (LATENCY > 0) ? LATENCY : 1;
  localparam logic [127:0] TAPS = 128'h2800_0005;
  localparam int OFF [10] = '{0, 1, 3, 6, 10, 15, 21, 28, 36, 45};
  state_t state_q, state_d;
  logic [127:0] din_q, din_d, lfsr_q, lfsr_d, exp_now, chk_e;
  logic [31:0] idx_q, idx_d, last_q, last_d, ffi_q, ffi_d, chk_i;
  logic [2:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] mc_q, mc_d;
  logic ffv_q, ffv_d, pass_q, pass_d, chk_v, miss;
  logic [D-1:0] pv_q, pv_d;
  logic [D:0] pv_ext;
  logic [127:0] pe_q [D], pe_d [D];
  logic [31:0] pi_q [D], pi_d [D];
  // Result field at a b-slot flags a zero a-field and vice versa; the six 6-bit tail fields reuse those flags.
  function automatic logic [127:0] golden(input logic [127:0] x);
    logic [127:0] o, m;
    o = '0;
    for (int i = 0; i < 9; i++) begin
      m = (128'd1 << (OFF[i+1] - OFF[i])) - 128'd1;
      o[OFF[i]] = ((x >> (45 + OFF[i])) & m) == '0;
      o[45 + OFF[i]] = ((x >> OFF[i]) & m) == '0;
    end
    o[90] = o[36];
    o[96] = o[36];
    o[102] = o[3];
    o[108] = o[48];
    o[114] = o[0];
    o[120] = o[45];
    return o;
  endfunction
  function automatic logic [127:0] step(input logic [127:0] s);
    return {s[126:0], 1'b0} ^ (s[127] ? TAPS : '0);
  endfunction
  always_comb begin
    exp_now = golden(din_q);
    chk_v = (LATENCY == 0) ? state_q == RUN : pv_q[D-1];
    chk_e = (LATENCY == 0) ? exp_now : pe_q[D-1];
    chk_i = (LATENCY == 0) ? idx_q : pi_q[D-1];
    pv_ext = {pv_q, state_q == RUN};
    pv_d = pv_ext[D-1:0];
    pe_d[0] = exp_now;
    pi_d[0] = idx_q;
    for (int i = 1; i < D; i++) begin
      pe_d[i] = pe_q[i-1];
      pi_d[i] = pi_q[i-1];
    end
    miss = chk_v && (dut_out != chk_e);
    mc_d = (miss && mc_q != '1) ? mc_q + 1'b1 : mc_q;
    ffv_d = ffv_q | miss;
    ffi_d = (miss && !ffv_q) ? chk_i : ffi_q;
    state_d = state_q;
    din_d = din_q;
    lfsr_d = lfsr_q;
    idx_d = idx_q;
    last_d = last_q;
    dcnt_d = dcnt_q;
    if (state_q == IDLE && start) begin
      mc_d = '0;
      ffv_d = 1'b0;
      ffi_d = '0;
      din_d = '0;
      idx_d = '0;
      last_d = num_vectors - 32'd1;
      lfsr_d = (seed == '0) ? 128'd1 : seed;
      state_d = (num_vectors == '0) ? DONE : RUN;
    end else if (state_q == RUN) begin
      if (idx_q == last_q || abort) begin
        state_d = (LATENCY == 0) ? DONE : DRAIN;
        dcnt_d = 3'(LATENCY - 1);
      end else begin
        idx_d = idx_q + 32'd1;
        din_d = (idx_q == '0) ? '1 : lfsr_q;
        lfsr_d = (idx_q == '0) ? lfsr_q : step(lfsr_q);
      end
    end else if (state_q == DRAIN) begin
      state_d = (dcnt_q == '0) ? DONE : DRAIN;
      dcnt_d = dcnt_q - 3'd1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    pass_d = (state_d == DONE) && (mc_d == '0);
  end
  always_ff @(posedge clk) begin
    pe_q <= pe_d;
    pi_q <= pi_d;
    if (rst) begin
      state_q <= IDLE;
      din_q <= '0;
      lfsr_q <= 128'd1;
      idx_q <= '0;
      last_q <= '0;
      dcnt_q <= '0;
      mc_q <= '0;
      ffv_q <= 1'b0;
      ffi_q <= '0;
      pass_q <= 1'b0;
      pv_q <= '0;
    end else begin
      state_q <= state_d;
      din_q <= din_d;
      lfsr_q <= lfsr_d;
      idx_q <= idx_d;
      last_q <= last_d;
      dcnt_q <= dcnt_d;
      mc_q <= mc_d;
      ffv_q <= ffv_d;
      ffi_q <= ffi_d;
      pass_q <= pass_d;
      pv_q <= pv_d;
    end
  end
  assign dut_in = din_q;
  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = state_q == DONE;
  assign pass = pass_q;
  assign mismatch_count = mc_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx = ffi_q;
endmodule

// File: tb/tb_lognot_cosim_sequencer.sv
// tb_lognot_cosim_sequencer: directed runs of the sequencer against a behavioural datapath at latencies 1 and 3
module tb_lognot_cosim_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [31:0] nv = '0;
  logic [127:0] seed = '0;
  logic [127:0] din1, din3, dout1, dout3, p1;
  logic [127:0] p3 [3];
  logic busy1, busy3, done1, done3, pass1, pass3, ffv1, ffv3;
  logic [15:0] mc1, mc3, rmc1, rmc3;
  logic [31:0] ffi1, ffi3, rffi1, rffi3;
  logic rpass1, rpass3, rffv1, rffv3;
  logic [127:0] h [4];
  int total = 0, bad = 0, fault = 0;
  int dc1, dc3, bc1, bc3;
  localparam logic [127:0] S = {1'b1, 126'd0, 1'b1};

  always #5 clk = ~clk;

  lognot_cosim_sequencer #(.LATENCY(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_vectors(nv), .seed(seed),
    .dut_in(din1), .dut_out(dout1), .busy(busy1), .done(done1), .pass(pass1),
    .mismatch_count(mc1), .first_fail_valid(ffv1), .first_fail_idx(ffi1));
  lognot_cosim_sequencer #(.LATENCY(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_vectors(nv), .seed(seed),
    .dut_in(din3), .dut_out(dout3), .busy(busy3), .done(done3), .pass(pass3),
    .mismatch_count(mc3), .first_fail_valid(ffv3), .first_fail_idx(ffi3));

  function automatic logic [127:0] model(input logic [127:0] x);
    logic [127:0] o;
    o = '0;
    o[0] = x[45] == 0;        o[1] = x[47:46] == 0;     o[3] = x[50:48] == 0;
    o[6] = x[54:51] == 0;     o[10] = x[59:55] == 0;    o[15] = x[65:60] == 0;
    o[21] = x[72:66] == 0;    o[28] = x[80:73] == 0;    o[36] = x[89:81] == 0;
    o[45] = x[0] == 0;        o[46] = x[2:1] == 0;      o[48] = x[5:3] == 0;
    o[51] = x[9:6] == 0;      o[55] = x[14:10] == 0;    o[60] = x[20:15] == 0;
    o[66] = x[27:21] == 0;    o[73] = x[35:28] == 0;    o[81] = x[44:36] == 0;
    o[90] = x[89:81] == 0;    o[96] = x[89:81] == 0;    o[102] = x[50:48] == 0;
    o[108] = x[5:3] == 0;     o[114] = x[45] == 0;      o[120] = x[0] == 0;
    return o;
  endfunction

  // fault 1: out[0] stuck low; 2: inverted on the all-ones vector; 3: always inverted
  function automatic logic [127:0] dp(input logic [127:0] x, input int f);
    logic [127:0] y;
    y = model(x);
    if (f == 1) y[0] = 1'b0;
    if (f == 2 && x == '1) y = ~y;
    if (f == 3) y = ~y;
    return y;
  endfunction

  always @(posedge clk) begin
    p1 <= din1;
    p3[0] <= din3;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  always_comb begin
    dout1 = dp(p1, fault);
    dout3 = dp(p3[2], fault);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [31:0] n, input logic [127:0] s, input int ab, input int fm);
    int c;
    fault = fm;
    nv = n;
    seed = s;
    dc1 = 0; dc3 = 0; bc1 = 0; bc3 = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while ((dc1 == 0 || dc3 == 0) && c < int'(n) + 40) begin
      abort = (c == ab);
      if (c >= 1 && c <= 4) h[c-1] = din1;
      bc1 += int'(busy1);
      bc3 += int'(busy3);
      if (done1 && dc1 == 0) begin
        dc1 = c; rpass1 = pass1; rmc1 = mc1; rffv1 = ffv1; rffi1 = ffi1;
      end
      if (done3 && dc3 == 0) begin
        dc3 = c; rpass3 = pass3; rmc3 = mc3; rffv3 = ffv3; rffi3 = ffi3;
      end
      @(negedge clk);
      c++;
    end
    abort = 1'b0;
    chk("run_finished", {dc1 != 0, dc3 != 0}, 2'b11);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outs", {busy1, done1, pass1, ffv1, busy3, done3, pass3, ffv3}, 8'd0);
    chk("rst_din", din1, '0);
    chk("rst_mc", mc3, 16'd0);
    chk("rst_ffi", ffi1, 32'd0);
    rst = 1'b0;
    // two vectors, correct datapath
    run(32'd2, 128'd7, -1, 0);
    chk("t1_vec0", h[0], '0);
    chk("t1_vec1", h[1], '1);
    chk("t1_done1", dc1, 4);
    chk("t1_busy1", bc1, 3);
    chk("t1_done3", dc3, 6);
    chk("t1_pass", {rpass1, rpass3, rffv1, rffv3}, 4'b1100);
    chk("t1_mc", {rmc1, rmc3}, 32'd0);
    // long run, zero seed coerced to 1
    run(32'd1000, '0, -1, 0);
    chk("t2_vec2", h[2], 128'd1);
    chk("t2_vec3", h[3], 128'd2);
    chk("t2_busy1", bc1, 1001);
    chk("t2_busy3", bc3, 1003);
    chk("t2_pass", {rpass1, rpass3}, 2'b11);
    // out[0] stuck low; seed with MSB set exercises the feedback taps
    run(32'd4, S, -1, 1);
    chk("t3_vec2", h[2], S);
    chk("t3_vec3", h[3], 128'h2800_0007);
    chk("t3_pass", {rpass1, rpass3}, 2'b00);
    chk("t3_mc1", rmc1, 16'd3);
    chk("t3_mc3", rmc3, 16'd3);
    chk("t3_ff", {rffv1, rffi1, rffv3, rffi3}, {1'b1, 32'd0, 1'b1, 32'd0});
    // zero vectors
    run(32'd0, 128'd5, -1, 0);
    chk("t4_done", {dc1, dc3}, {32'd1, 32'd1});
    chk("t4_busy", {bc1, bc3}, 64'd0);
    chk("t4_pass", {rpass1, rpass3}, 2'b11);
    // abort on the 5th RUN cycle with an always-failing datapath
    run(32'd100, 128'h1234_5678, 5, 3);
    chk("t5_mc1", rmc1, 16'd5);
    chk("t5_mc3", rmc3, 16'd5);
    chk("t5_done1", dc1, 7);
    chk("t5_done3", dc3, 9);
    chk("t5_busy3", bc3, 8);
    chk("t5_ffi", {rffi1, rffi3}, 64'd0);
    // only the all-ones vector fails
    run(32'd5, 128'hdead_beef_0000_1111, -1, 2);
    chk("t6_ffi", {rffi1, rffi3}, {32'd1, 32'd1});
    chk("t6_mc", {rmc1, rmc3}, {16'd1, 16'd1});
    chk("t6_pass", {rpass1, rpass3, rffv1, rffv3}, 4'b0011);
    // reset while u3 drains with a mismatch already counted
    fault = 3;
    nv = 32'd3;
    seed = 128'd9;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t7_pre", {busy3, mc3}, {1'b1, 16'd1});
    rst = 1'b1;
    @(negedge clk);
    chk("t7_outs", {busy1, done1, pass1, ffv1, busy3, done3, pass3, ffv3}, 8'd0);
    chk("t7_cnt", {mc1, mc3, ffi3}, '0);
    chk("t7_din", din3, '0);
    rst = 1'b0;
    run(32'd10, 128'd3, -1, 0);
    chk("t7_rerun", {rpass1, rpass3, rmc1, rmc3}, {2'b11, 32'd0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
